// File: rtl/sprite_pkg.sv
// Shared sprite constants: ids, direction codes, position widths and reset positions.
// Also used by the position-update datapath.
package sprite_pkg;

   localparam int NUM_SPRITES = 5;
   localparam int X_W         = 11;
   localparam int Y_W         = 10;
   localparam int BLOCK_STEP  = 15;

   localparam int PACMAN = 0;
   localparam int BLINKY = 1;
   localparam int PINKY  = 2;
   localparam int INKY   = 3;
   localparam int CLYDE  = 4;

   localparam logic [3:0] DIR_RIGHT = 4'b0001;
   localparam logic [3:0] DIR_UP    = 4'b0010;
   localparam logic [3:0] DIR_DOWN  = 4'b0100;
   localparam logic [3:0] DIR_LEFT  = 4'b1000;

   localparam logic [NUM_SPRITES-1:0][X_W-1:0] RESET_POS_X = {NUM_SPRITES{X_W'(10)}};
   localparam logic [NUM_SPRITES-1:0][Y_W-1:0] RESET_POS_Y = {NUM_SPRITES{Y_W'(10)}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CAPTURE,
      ST_DONE
   } sched_state_t;

endpackage

// File: rtl/sprite_move_scheduler.sv
// Walks the shared position updater across all sprites once per accepted tick,
// owns the sprite position registers and reports Pacman/ghost collisions.
module sprite_move_scheduler
   import sprite_pkg::*;
#(
   parameter int UPD_LATENCY    = 1,
   parameter int GHOST_TICK_DIV = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_tick,
   input  logic                        i_pause,
   input  logic [3:0]                  i_dir_pacman,
   input  logic [4*(NUM_SPRITES-1)-1:0] i_dir_ghosts,
   output logic [X_W-1:0]              o_upd_curr_x,
   output logic [Y_W-1:0]              o_upd_curr_y,
   output logic [3:0]                  o_upd_dir,
   output logic [2:0]                  o_upd_sprite,
   input  logic [X_W-1:0]              i_upd_new_x,
   input  logic [Y_W-1:0]              i_upd_new_y,
   output logic [NUM_SPRITES*X_W-1:0]  o_pos_x_flat,
   output logic [NUM_SPRITES*Y_W-1:0]  o_pos_y_flat,
   output logic                        o_busy,
   output logic                        o_frame_done,
   output logic [NUM_SPRITES-2:0]      o_collide_mask,
   output logic                        o_overrun
);

   localparam int IDX_W  = 3;
   localparam int DIV_W  = (GHOST_TICK_DIV > 1) ? $clog2(GHOST_TICK_DIV) : 1;
   localparam int WAIT_W = (UPD_LATENCY > 1) ? $clog2(UPD_LATENCY) : 1;

   sched_state_t r_state, w_state_nxt;

   logic [IDX_W-1:0]                  r_idx;
   logic [DIV_W-1:0]                  r_div_cnt;
   logic                              r_ghosts_en;
   logic [WAIT_W-1:0]                 r_wait_cnt;
   logic [NUM_SPRITES-1:0][3:0]       r_dir;
   logic [NUM_SPRITES-1:0][X_W-1:0]   r_pos_x;
   logic [NUM_SPRITES-1:0][Y_W-1:0]   r_pos_y;
   logic [X_W-1:0]                    r_upd_curr_x;
   logic [Y_W-1:0]                    r_upd_curr_y;
   logic [3:0]                        r_upd_dir;
   logic [2:0]                        r_upd_sprite;
   logic                              r_busy;
   logic                              r_frame_done;
   logic                              r_overrun;
   logic [NUM_SPRITES-2:0]            r_collide;

   logic                              w_accept;
   logic                              w_last;
   logic                              w_wait_last;
   logic                              w_div_wrap;
   logic [NUM_SPRITES-2:0]            w_collide;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept) w_state_nxt = ST_ISSUE;
         ST_ISSUE:   w_state_nxt = ST_WAIT;
         ST_WAIT:    if (w_wait_last) w_state_nxt = ST_CAPTURE;
         ST_CAPTURE: w_state_nxt = w_last ? ST_DONE : ST_ISSUE;
         ST_DONE:    w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Decode of the current state; with ghosts disabled Pacman is the last sprite
   always_comb begin
      w_accept    = (r_state == ST_IDLE) && i_tick && !i_pause;
      w_last      = (r_idx == IDX_W'(NUM_SPRITES-1)) || !r_ghosts_en;
      w_wait_last = (r_wait_cnt == WAIT_W'(UPD_LATENCY-1));
      w_div_wrap  = (r_div_cnt == DIV_W'(GHOST_TICK_DIV-1));
   end

   for (genvar g = 1; g < NUM_SPRITES; g++) begin : g_collide
      assign w_collide[g-1] = (r_pos_x[0] == r_pos_x[g]) && (r_pos_y[0] == r_pos_y[g]);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idx        <= '0;
         r_div_cnt    <= '0;
         r_ghosts_en  <= 1'b0;
         r_wait_cnt   <= '0;
         r_dir        <= '0;
         r_pos_x      <= RESET_POS_X;
         r_pos_y      <= RESET_POS_Y;
         r_upd_curr_x <= '0;
         r_upd_curr_y <= '0;
         r_upd_dir    <= '0;
         r_upd_sprite <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
         r_collide    <= '0;
      end else begin
         // DONE still counts as busy, so a tick landing there is dropped
         r_overrun    <= i_tick && !i_pause && r_busy;
         r_frame_done <= (r_state == ST_DONE);

         if (w_accept) begin
            r_dir[0] <= i_dir_pacman;
            for (int g = 1; g < NUM_SPRITES; g++)
               r_dir[g] <= i_dir_ghosts[4*g-4 +: 4];
            r_busy      <= 1'b1;
            r_idx       <= '0;
            r_ghosts_en <= w_div_wrap;
            r_div_cnt   <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
         end

         case (r_state)
            ST_ISSUE: begin
               for (int i = 0; i < NUM_SPRITES; i++) begin
                  if (r_idx == IDX_W'(i)) begin
                     r_upd_curr_x <= r_pos_x[i];
                     r_upd_curr_y <= r_pos_y[i];
                     r_upd_dir    <= r_dir[i];
                  end
               end
               r_upd_sprite <= r_idx;
               r_wait_cnt   <= '0;
            end
            ST_WAIT: r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            ST_CAPTURE: begin
               for (int i = 0; i < NUM_SPRITES; i++) begin
                  if (r_idx == IDX_W'(i)) begin
                     r_pos_x[i] <= i_upd_new_x;
                     r_pos_y[i] <= i_upd_new_y;
                  end
               end
               if (!w_last) r_idx <= r_idx + IDX_W'(1);
            end
            ST_DONE: begin
               r_collide <= w_collide;
               r_busy    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_upd_curr_x   = r_upd_curr_x;
   assign o_upd_curr_y   = r_upd_curr_y;
   assign o_upd_dir      = r_upd_dir;
   assign o_upd_sprite   = r_upd_sprite;
   assign o_pos_x_flat   = r_pos_x;
   assign o_pos_y_flat   = r_pos_y;
   assign o_busy         = r_busy;
   assign o_frame_done   = r_frame_done;
   assign o_collide_mask = r_collide;
   assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Bench for sprite_move_scheduler: table of frames with fixed expectations,
// hand sequences for pause / mid-frame reset, then random frames against a frame-level model.
module tb_sprite_move_scheduler;
   import sprite_pkg::*;

   logic        clk = 1'b0;
   logic        rst, tick, pause;
   logic [3:0]  dir_p;
   logic [15:0] dir_g;
   logic [10:0] upd_curr_x, upd_new_x;
   logic [9:0]  upd_curr_y, upd_new_y;
   logic [3:0]  upd_dir;
   logic [2:0]  upd_sprite;
   logic [54:0] pos_x_flat;
   logic [49:0] pos_y_flat;
   logic        busy, frame_done, overrun;
   logic [3:0]  collide_mask;

   int n_tests = 0;
   int n_fail  = 0;

   logic [10:0] ref_x [5];
   logic [9:0]  ref_y [5];
   int          ref_div;
   logic [3:0]  ref_mask;

   always #5 clk = ~clk;

   sprite_move_scheduler #(.UPD_LATENCY(1), .GHOST_TICK_DIV(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_pause(pause),
      .i_dir_pacman(dir_p), .i_dir_ghosts(dir_g),
      .o_upd_curr_x(upd_curr_x), .o_upd_curr_y(upd_curr_y),
      .o_upd_dir(upd_dir), .o_upd_sprite(upd_sprite),
      .i_upd_new_x(upd_new_x), .i_upd_new_y(upd_new_y),
      .o_pos_x_flat(pos_x_flat), .o_pos_y_flat(pos_y_flat),
      .o_busy(busy), .o_frame_done(frame_done),
      .o_collide_mask(collide_mask), .o_overrun(overrun)
   );

   // Movement rule of the position updater: one block per move, illegal codes hold
   function automatic logic [20:0] step(input logic [10:0] x, input logic [9:0] y,
                                        input logic [3:0] d);
      logic [10:0] nx;
      logic [9:0]  ny;
      nx = x;
      ny = y;
      case (d)
         4'b0001: nx = x + 11'd15;
         4'b0010: ny = y - 10'd15;
         4'b0100: ny = y + 10'd15;
         4'b1000: nx = x - 11'd15;
         default: ;
      endcase
      return {nx, ny};
   endfunction

   // Updater with one cycle of latency
   always @(posedge clk) {upd_new_x, upd_new_y} <= step(upd_curr_x, upd_curr_y, upd_dir);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         ref_x[i] = 11'd10;
         ref_y[i] = 10'd10;
      end
      ref_div  = 0;
      ref_mask = 4'b0;
   endtask

   task automatic check_all_pos(input string tag);
      for (int i = 0; i < 5; i++) begin
         check({tag, "_x"}, pos_x_flat[11*i +: 11], ref_x[i]);
         check({tag, "_y"}, pos_y_flat[10*i +: 10], ref_y[i]);
      end
   endtask

   function automatic logic [3:0] rand_dir();
      case ($urandom_range(0, 5))
         0: return 4'b0001;
         1: return 4'b0010;
         2: return 4'b0100;
         3: return 4'b1000;
         4: return 4'b0000;
         default: return 4'($urandom);
      endcase
   endfunction

   // One accepted tick; extra_at >= 0 injects a second tick c cycles into the frame
   task automatic run_frame(input logic [3:0] dp, input logic [15:0] dg, input int extra_at,
                            output int lat);
      logic [3:0]  dirs [5];
      logic [10:0] pre_x [5];
      logic [9:0]  pre_y [5];
      logic [20:0] nxt;
      bit gen;
      int lat_exp, e, ovr_cnt, fd_extra, busy_extra;
      dirs[0] = dp;
      for (int g = 1; g < 5; g++) dirs[g] = dg[4*g-4 +: 4];
      for (int i = 0; i < 5; i++) begin
         pre_x[i] = ref_x[i];
         pre_y[i] = ref_y[i];
      end
      gen     = (ref_div == 1);
      lat_exp = gen ? 16 : 4;
      e       = (extra_at >= lat_exp) ? lat_exp - 1 : extra_at;
      ovr_cnt = 0;
      lat     = -1;

      @(negedge clk);
      dir_p = dp; dir_g = dg; tick = 1'b1; pause = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tick = 1'b0;
      dir_p = 4'($urandom);
      dir_g = 16'($urandom);
      if (e == 0) tick = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         tick = 1'b0;
         if (overrun) ovr_cnt++;
         if (c == 1) check("busy_in_frame", busy, 1);
         for (int k = 0; k < 5; k++) begin
            if (c == 3*k+1 && (k == 0 || gen)) begin
               check("upd_sprite", upd_sprite, k);
               check("upd_curr_x", upd_curr_x, pre_x[k]);
               check("upd_curr_y", upd_curr_y, pre_y[k]);
               check("upd_dir", upd_dir, dirs[k]);
            end
         end
         if (e >= 0 && c == e + 1) check("overrun_pulse", overrun, 1);
         if (frame_done) begin
            lat = c;
            break;
         end
         if (c == e) tick = 1'b1;
      end
      check("frame_latency", lat, lat_exp);

      for (int i = 0; i < 5; i++) begin
         if (i == 0 || gen) begin
            nxt = step(pre_x[i], pre_y[i], dirs[i]);
            ref_x[i] = nxt[20:10];
            ref_y[i] = nxt[9:0];
         end
      end
      for (int g = 1; g < 5; g++)
         ref_mask[g-1] = (ref_x[0] == ref_x[g]) && (ref_y[0] == ref_y[g]);
      ref_div = gen ? 0 : ref_div + 1;

      check("collide_mask", collide_mask, ref_mask);
      check("busy_after", busy, 0);
      check_all_pos("pos");
      check("overrun_count", ovr_cnt, (e >= 0) ? 1 : 0);

      fd_extra = 0;
      busy_extra = 0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         if (frame_done) fd_extra++;
         if (busy) busy_extra++;
      end
      check("single_frame_done", fd_extra, 0);
      check("no_restart", busy_extra, 0);
   endtask

   typedef struct {
      logic [3:0]  dp;
      logic [15:0] dg;
      int          extra;
      int          lat;
      logic [10:0] px;
      logic [9:0]  py;
      logic [3:0]  mask;
   } vec_t;

   vec_t tbl [5];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      tbl[0] = '{4'b0001, 16'h0000, -1,  4, 11'd25, 10'd10, 4'b0000};
      tbl[1] = '{4'b0000, 16'h0000,  5, 16, 11'd25, 10'd10, 4'b0000};
      tbl[2] = '{4'b1000, 16'h0001, -1,  4, 11'd10, 10'd10, 4'b1111};
      tbl[3] = '{4'b0100, 16'h0341, 15, 16, 11'd10, 10'd25, 4'b0010};
      tbl[4] = '{4'b0010, 16'h0000,  0,  4, 11'd10, 10'd10, 4'b1100};

      rst = 1'b1; tick = 1'b0; pause = 1'b0; dir_p = '0; dir_g = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_mask", collide_mask, 0);
      check("rst_upd_sprite", upd_sprite, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overrun", overrun, 0);
      check_all_pos("rst_pos");

      // Paused ticks: no frame, no overrun, divider untouched
      repeat (3) begin
         @(negedge clk);
         tick = 1'b1; pause = 1'b1; dir_p = 4'b0001;
         @(posedge clk);
         @(negedge clk);
         tick = 1'b0;
         check("pause_busy", busy, 0);
         check("pause_overrun", overrun, 0);
      end
      pause = 1'b0;
      @(negedge clk);
      check("pause_busy2", busy, 0);
      check_all_pos("pause_pos");

      foreach (tbl[i]) begin
         run_frame(tbl[i].dp, tbl[i].dg, tbl[i].extra, lat);
         check("tbl_lat", lat, tbl[i].lat);
         check("tbl_pac_x", pos_x_flat[10:0], tbl[i].px);
         check("tbl_pac_y", pos_y_flat[9:0], tbl[i].py);
         check("tbl_mask", collide_mask, tbl[i].mask);
      end

      // Reset while sprite 2 is waiting on the updater in a full frame
      @(negedge clk);
      dir_p = 4'b0001; dir_g = 16'h1111; tick = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tick = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("pre_rst_sprite", upd_sprite, 2);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_fd", frame_done, 0);
      check("mid_rst_mask", collide_mask, 0);
      check("mid_rst_upd_sprite", upd_sprite, 0);
      check_all_pos("mid_rst_pos");
      begin
         int fd_cnt = 0;
         repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_done || busy) fd_cnt++;
         end
         check("mid_rst_quiet", fd_cnt, 0);
      end

      // Random frames and paused ticks against the model
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 4) == 0) begin
            @(negedge clk);
            tick = 1'b1; pause = 1'b1; dir_p = rand_dir();
            @(posedge clk);
            @(negedge clk);
            tick = 1'b0; pause = 1'b0;
            check("rnd_pause_busy", busy, 0);
            check("rnd_pause_overrun", overrun, 0);
         end else begin
            logic [15:0] dg;
            for (int g = 0; g < 4; g++) dg[4*g +: 4] = rand_dir();
            run_frame(rand_dir(), dg,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1, lat);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
